// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage register ({valid, payload}) with stall,
// flush and a LIFO interrupt shadow stack that saves and restores the
// in-flight stage contents across nested interrupts.
module pipe_stage_reg #(
    parameter int WIDTH      = 160,
    parameter int SAVE_DEPTH = 2,
    parameter int CW         = $clog2(SAVE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             int_save,
    input  logic             int_restore,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    save_count,
    output logic             save_full,
    output logic             save_empty,
    output logic             save_ovf,
    output logic             restore_unf
);

    localparam logic [CW-1:0] DEPTH_C = CW'(SAVE_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    // Stage register holds {valid, payload}; payload is kept zero while invalid.
    logic [WIDTH:0]  r_q, r_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic            full, empty, push;
    logic [WIDTH:0]  stk_rd [SAVE_DEPTH];
    logic [WIDTH:0]  top;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A push only happens when save wins arbitration and there is room.
    assign push  = !flush && int_save && !full;

    // Select the top-of-stack entry (index count-1) without a variable index.
    always_comb begin
        top = '0;
        for (int i = 0; i < SAVE_DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
                top = stk_rd[i];
            end
        end
    end

    // Next-state for the stage register, occupancy and sticky error flags.
    always_comb begin
        r_d     = r_q;
        count_d = count_q;
        // Clear first so a same-cycle error event below re-sets the flag.
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        if (flush) begin
            r_d = '0;
        end else if (int_save) begin
            r_d = '0;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + ONE_C;
            end
        end else if (int_restore) begin
            if (empty) begin
                r_d   = '0;
                unf_d = 1'b1;
            end else begin
                r_d     = top;
                count_d = count_q - ONE_C;
            end
        end else if (!stall) begin
            r_d = in_valid ? {1'b1, in_data} : '0;
        end
    end

    // Stage register, occupancy and error flag state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            r_q     <= r_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Shadow stack: entry gi captures the stage register when it is the
    // next free slot at push time. Entries are cleared by reset so stale
    // contexts never leak after a reset mid-interrupt.
    generate
        for (genvar gi = 0; gi < SAVE_DEPTH; gi++) begin : g_stk
            logic [WIDTH:0] entry_q, entry_d;

            // Write this entry only when it is the slot being pushed.
            always_comb begin
                entry_d = (push && (count_q == CW'(gi))) ? r_q : entry_q;
            end

            // Stack entry storage.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign stk_rd[gi] = entry_q;
        end
    endgenerate

    // All outputs come straight from state or a decode of the occupancy.
    assign out_valid   = r_q[WIDTH];
    assign out_data    = r_q[WIDTH-1:0];
    assign save_count  = count_q;
    assign save_full   = full;
    assign save_empty  = empty;
    assign save_ovf    = ovf_q;
    assign restore_unf = unf_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg
// against a queue-based model of the stage register and shadow stack.
module tb_pipe_stage_reg;

    localparam int W  = 160;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          stall, flush, int_save, int_restore, err_clr;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] save_count;
    logic          save_full, save_empty, save_ovf, restore_unf;

    int ncomp = 0;
    int nfail = 0;

    // Reference model state
    logic [W:0] m_r;
    logic [W:0] m_stk[$];
    logic       m_ovf, m_unf;

    pipe_stage_reg #(.WIDTH(W), .SAVE_DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .stall       (stall),
        .flush       (flush),
        .int_save    (int_save),
        .int_restore (int_restore),
        .err_clr     (err_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .save_count  (save_count),
        .save_full   (save_full),
        .save_empty  (save_empty),
        .save_ovf    (save_ovf),
        .restore_unf (restore_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"},   (W+1)'(out_valid),   (W+1)'(m_r[W]));
        chk({tag, ".out_data"},    (W+1)'(out_data),    (W+1)'(m_r[W-1:0]));
        chk({tag, ".save_count"},  (W+1)'(save_count),  (W+1)'(m_stk.size()));
        chk({tag, ".save_full"},   (W+1)'(save_full),   (W+1)'(m_stk.size() == D));
        chk({tag, ".save_empty"},  (W+1)'(save_empty),  (W+1)'(m_stk.size() == 0));
        chk({tag, ".save_ovf"},    (W+1)'(save_ovf),    (W+1)'(m_ovf));
        chk({tag, ".restore_unf"}, (W+1)'(restore_unf), (W+1)'(m_unf));
    endtask

    task automatic model_reset();
        m_r = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model by the priority
    // rules, then sample the DUT shortly after the edge.
    task automatic step(input string tag, input logic iv, input logic [W-1:0] id,
                        input logic st, input logic fl, input logic sv,
                        input logic rs, input logic ec);
        in_valid = iv; in_data = id; stall = st; flush = fl;
        int_save = sv; int_restore = rs; err_clr = ec;
        if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (fl) begin
            m_r = '0;
        end else if (sv) begin
            if (m_stk.size() < D) m_stk.push_back(m_r);
            else m_ovf = 1'b1;
            m_r = '0;
        end else if (rs) begin
            if (m_stk.size() > 0) m_r = m_stk.pop_back();
            else begin
                m_r = '0;
                m_unf = 1'b1;
            end
        end else if (!st) begin
            m_r = iv ? {1'b1, id} : '0;
        end
        @(posedge clk);
        #1;
        $display("step %-10s iv=%b st=%b fl=%b sv=%b rs=%b ec=%b -> ov=%b od=%h cnt=%0d ovf=%b unf=%b",
                 tag, iv, st, fl, sv, rs, ec, out_valid, out_data, save_count, save_ovf, restore_unf);
        check_all(tag);
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [W-1:0] z;
        z = '0;
        reset_n = 1'b0;
        in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0;
        int_save = 1'b0; int_restore = 1'b0; err_clr = 1'b0;
        model_reset();
        #1;
        check_all("por");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Streaming with one-cycle latency
        step("load1", 1, W'(32'h1), 0, 0, 0, 0, 0);
        step("load2", 1, W'(32'h2), 0, 0, 0, 0, 0);
        step("load3", 1, W'(32'h3), 0, 0, 0, 0, 0);

        // Asynchronous reset mid-stream, checked before any clock edge
        in_data = W'(32'h4);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Stall holds, stall+flush bubbles
        step("ld_aa",   1, W'(32'hAA), 0, 0, 0, 0, 0);
        step("stall1",  1, W'(32'h55), 1, 0, 0, 0, 0);
        step("stall2",  0, W'(32'h66), 1, 0, 0, 0, 0);
        step("stall3",  1, W'(32'h77), 1, 0, 0, 0, 0);
        step("st_fl",   1, W'(32'h88), 1, 1, 0, 0, 0);

        // Nested save then LIFO restore
        step("ld_11",   1, W'(32'h11), 0, 0, 0, 0, 0);
        step("save1",   1, W'(32'h99), 0, 0, 1, 0, 0);
        step("ld_22",   1, W'(32'h22), 0, 0, 0, 0, 0);
        step("save2",   0, z,          0, 0, 1, 0, 0);
        step("rest1",   1, W'(32'hEE), 0, 0, 0, 1, 0);
        step("rest2",   1, W'(32'hEE), 1, 0, 0, 1, 0);

        // Overflow, underflow, error clear
        step("ld_a",    1, W'(32'h5A), 0, 0, 0, 0, 0);
        step("sv_a",    0, z,          0, 0, 1, 0, 0);
        step("ld_b",    1, W'(32'h5B), 0, 0, 0, 0, 0);
        step("sv_b",    0, z,          0, 0, 1, 0, 0);
        step("ld_c",    1, W'(32'h5C), 0, 0, 0, 0, 0);
        step("sv_ovf",  0, z,          0, 0, 1, 0, 0);
        step("ovf_clr", 1, W'(32'h5D), 0, 0, 1, 0, 1);
        step("rs_b",    0, z,          0, 0, 0, 1, 0);
        step("rs_a",    0, z,          0, 0, 0, 1, 0);
        step("ld_e",    1, W'(32'h5E), 0, 0, 0, 0, 0);
        step("rs_unf",  0, z,          0, 0, 0, 1, 0);
        step("err_clr", 0, z,          0, 0, 0, 0, 1);

        // flush beats save; save beats restore
        step("ld_33",   1, W'(32'h33), 0, 0, 0, 0, 0);
        step("fl_sv",   1, W'(32'h44), 0, 1, 1, 0, 0);
        step("ld_34",   1, W'(32'h34), 0, 0, 0, 0, 0);
        step("sv_rs",   1, W'(32'h45), 0, 0, 1, 1, 0);
        step("rs_34",   0, z,          0, 0, 0, 1, 0);

        // Invalid input zeroes payload
        step("inv",     0, W'(32'hFFFF_FFFF), 0, 0, 0, 0, 0);

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 1'($urandom_range(0, 3) != 0), rnd_data(),
                 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
